// File: rtl/dec_addr_seq.sv
// dec_addr_seq
//
// Address sequencer that drives the 4-bit select inputs of a 4-to-16 decoder
// (addr[3]=A ... addr[0]=D). It scans a programmable range first..last,
// holding each address for dwell+1 cycles. A scan runs either once, ending
// with a one-cycle done pulse, or continuously with wrap-around.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous, active-low reset
//   start  in   level-sampled; begins a scan when idle
//   stop   in   aborts a running scan; wins over start
//   first  in   [3:0]          first address of range (latched on start)
//   last   in   [3:0]          last address of range (latched on start)
//   dwell  in   [DWELL_W-1:0]  hold cycles minus one (latched on start)
//   cont   in   1 = wrap to first after last and repeat (latched on start)
//   addr   out  [3:0]  registered decoder select
//   en     out  registered; addr is valid for the decoder
//   busy   out  registered; scan in progress (same as en)
//   done   out  registered one-cycle pulse on normal completion
module dec_addr_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         first,
  input  logic [3:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               cont,
  output logic [3:0]         addr,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [3:0]         f_q;
  logic [3:0]         l_q;
  logic [DWELL_W-1:0] d_q;
  logic               c_q;
  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= 4'd0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      f_q   <= 4'd0;
      l_q   <= 4'd0;
      d_q   <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // done only lives for the single cycle spent here after a scan
          done <= 1'b0;
          if (start && !stop) begin
            f_q   <= first;
            l_q   <= last;
            d_q   <= dwell;
            c_q   <= cont;
            addr  <= first;
            cnt   <= dwell;
            en    <= 1'b1;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          done <= 1'b0;
          if (stop) begin
            // abort: addr keeps its value, no completion pulse
            en    <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (addr != l_q) begin
            // 4-bit add wraps 15 -> 0, which gives ranges with first > last
            addr <= addr + 4'd1;
            cnt  <= d_q;
          end else if (c_q) begin
            addr <= f_q;
            cnt  <= d_q;
          end else begin
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_addr_seq.sv
module tb_dec_addr_seq;

  localparam int DWELL_W = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [3:0]         first;
  logic [3:0]         last;
  logic [DWELL_W-1:0] dwell;
  logic               cont;
  logic [3:0]         addr;
  logic               en;
  logic               busy;
  logic               done;

  int checks;
  int failures;

  dec_addr_seq #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .first (first),
    .last  (last),
    .dwell (dwell),
    .cont  (cont),
    .addr  (addr),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Checks the outputs are idle-with-no-pulse.
  task automatic chk_idle(input string tag);
    chk({tag, ".en"},   8'(en),   8'd0);
    chk({tag, ".busy"}, 8'(busy), 8'd0);
    chk({tag, ".done"}, 8'(done), 8'd0);
  endtask

  // Expects address a driven with en for n consecutive cycles.
  task automatic expect_hold(input logic [3:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      chk("hold.addr", 8'(addr), 8'(a));
      chk("hold.en",   8'(en),   8'd1);
      chk("hold.busy", 8'(busy), 8'd1);
      chk("hold.done", 8'(done), 8'd0);
      @(negedge clk);
    end
  endtask

  // Expects the completion cycle, then done dropping on the next cycle.
  task automatic expect_done(input logic [3:0] a);
    chk("done.addr", 8'(addr), 8'(a));
    chk("done.en",   8'(en),   8'd0);
    chk("done.busy", 8'(busy), 8'd0);
    chk("done.done", 8'(done), 8'd1);
    @(negedge clk);
    chk("after_done.done", 8'(done), 8'd0);
    chk("after_done.en",   8'(en),   8'd0);
  endtask

  // One-cycle start pulse; returns at the first cycle of the scan.
  task automatic do_start(input logic [3:0] f, input logic [3:0] l,
                          input logic [DWELL_W-1:0] d, input logic c);
    first = f; last = l; dwell = d; cont = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    first = 4'd0; last = 4'd0; dwell = '0; cont = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst.addr", 8'(addr), 8'd0);
    chk_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // Full sweep 0..15, dwell 0
    do_start(4'd0, 4'd15, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) expect_hold(4'(i), 1);
    expect_done(4'd15);

    // Wrap range 14..1 with dwell 2
    do_start(4'd14, 4'd1, 4'd2, 1'b0);
    expect_hold(4'd14, 3);
    expect_hold(4'd15, 3);
    expect_hold(4'd0, 3);
    expect_hold(4'd1, 3);
    expect_done(4'd1);

    // Ignored inputs during a running scan
    do_start(4'd0, 4'd15, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin start = 1'b1; first = 4'd8; last = 4'd8; cont = 1'b1; end
      if (i == 6) begin start = 1'b0; cont = 1'b0; end
      expect_hold(4'(i), 1);
    end
    expect_done(4'd15);

    // start together with stop in IDLE does nothing
    first = 4'd5; last = 4'd7; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    chk_idle("startstop1");
    @(negedge clk);
    chk_idle("startstop2");
    start = 1'b0; stop = 1'b0;

    // Continuous 3..5, stop while addr=4
    do_start(4'd3, 4'd5, 4'd0, 1'b1);
    expect_hold(4'd3, 1);
    expect_hold(4'd4, 1);
    expect_hold(4'd5, 1);
    expect_hold(4'd3, 1);
    expect_hold(4'd4, 1);
    expect_hold(4'd5, 1);
    expect_hold(4'd3, 1);
    chk("cont.addr4", 8'(addr), 8'd4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop.addr", 8'(addr), 8'd4);
    chk_idle("stop");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("stop_after");
      chk("stop_after.addr", 8'(addr), 8'd4);
    end

    // Single address with dwell 1, then back-to-back start in the done cycle
    do_start(4'd9, 4'd9, 4'd1, 1'b0);
    expect_hold(4'd9, 2);
    chk("b2b.done", 8'(done), 8'd1);
    chk("b2b.en",   8'(en),   8'd0);
    first = 4'd2; last = 4'd3; dwell = '0; cont = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_hold(4'd2, 1);
    expect_hold(4'd3, 1);
    expect_done(4'd3);

    // Reset mid-scan, taking effect without a clock edge
    do_start(4'd0, 4'd15, 4'd3, 1'b1);
    expect_hold(4'd0, 4);
    expect_hold(4'd1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("amid.addr", 8'(addr), 8'd0);
    chk_idle("amid");
    @(negedge clk);
    chk("amid2.addr", 8'(addr), 8'd0);
    chk_idle("amid2");
    // Release with start already high: the first edge accepts it
    rst_n = 1'b1;
    first = 4'd6; last = 4'd6; dwell = '0; cont = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_hold(4'd6, 1);
    expect_done(4'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_addr_seq.md
# dec_addr_seq

Address sequencer that sits directly upstream of the 4-to-16 decoder and drives its 4-bit select inputs (A = addr[3] … D = addr[0]). It scans a programmable address range with a programmable dwell time per address and qualifies each address with an enable. It runs either once, ending with a done pulse, or continuously with wrap-around. It replaces free-running testbench stimulus with a controllable, handshaked source.

## Interface
- DWELL_W, 4, width of the dwell field; each address is held dwell+1 cycles.

- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  level-sampled; starts a scan when idle.
- stop  in  1  aborts a running scan; has priority over start.
- first  in  4  first address of range, sampled on accepted start.
- last  in  4  last address of range, sampled on accepted start.
- dwell  in  DWELL_W  hold cycles minus one, sampled on accepted start.
- cont  in  1  1 = wrap to first after last and repeat; sampled on accepted start.
- addr  out  4  registered decoder select (addr[3]=A … addr[0]=D).
- en  out  1  registered; addr is valid for the decoder.
- busy  out  1  registered; scan in progress (equals en).
- done  out  1  registered one-cycle pulse on normal completion.

## Operation
- FSM has two states, IDLE and RUN. Internal registers: f_q, l_q (4 b), d_q (DWELL_W), c_q (1), cnt (DWELL_W).
- Reset, asynchronous on rst_n low: state=IDLE; addr=0, en=0, busy=0, done=0; all internal registers 0.
- IDLE:
  - done clears to 0 every cycle unless set by the RUN exit edge.
  - start=1 and stop=0 → latch first/last/dwell/cont; addr<=first; cnt<=dwell; en,busy<=1; go to RUN.
  - start=1 and stop=1 → no action; stay in IDLE.
- RUN, in priority order:
  - stop=1 → en,busy<=0; done stays 0; go to IDLE. addr holds its current value.
  - cnt≠0 → cnt<=cnt−1; addr holds.
  - cnt=0 and addr≠l_q → addr<=addr+1 (mod 16: 15 wraps to 0); cnt<=d_q.
  - cnt=0, addr=l_q, c_q=1 → addr<=f_q; cnt<=d_q; stay in RUN.
  - cnt=0, addr=l_q, c_q=0 → en,busy<=0; done<=1; go to IDLE.
- Address-range rules:
  - The number of addresses per pass is N = ((l_q − f_q) mod 16) + 1.
  - first=last gives a single address.
  - first>last scans upward through the 15→0 wrap.
- start, first, last, dwell and cont are ignored while busy=1; latched values stay fixed for the whole scan.
- After a scan ends, addr holds its last driven value. Consumers must gate the decoder output with en.

## Timing
- Start latency: start is sampled at edge k; addr=first and en=busy=1 are visible after edge k, so addr is valid in the cycle following the start cycle.
- Hold time: each address is held exactly dwell+1 cycles.
- Single run (cont=0): en is high for exactly N×(dwell+1) cycles. done is high for exactly one cycle, the first cycle with en=0. busy falls on the same edge that done rises.
- Back-to-back scans: start asserted in the done cycle is accepted, since the block is already in IDLE. The next scan's first address appears after the following edge.
- Stop: stop sampled high at edge j drops en and busy after edge j, with no done pulse.
- Continuous mode: no gap between passes; addr goes last→first on consecutive cycles.
- Reset mid-scan: outputs go to reset values immediately, without waiting for a clock edge. After rst_n rises, the first edge can accept a start.

## Test plan
- Reset: rst_n=0 mid-scan, with no clock edge → addr=0, en=0, busy=0, done=0 immediately; all stay there until a start is accepted.
- Full sweep: first=0, last=15, dwell=0, cont=0, one-cycle start → addr 0,1,…,15 on 16 consecutive cycles with en=1; next cycle en=0, done=1; cycle after that done=0.
- Wrap range with dwell: first=14, last=1, dwell=2 → addr sequence 14,15,0,1, each held 3 cycles; en high 12 cycles; then a single done pulse.
- Continuous and stop: first=3, last=5, dwell=0, cont=1 → 3,4,5,3,4,5,…; stop asserted while addr=4 → en=busy=0 after that edge, addr stays 4, done never pulses.
- Ignored inputs: during a 0→15 scan, start=1 with first=8 → scan is unaffected. In IDLE, start=1 and stop=1 together → busy stays 0.
- Single address and back-to-back: first=last=9, dwell=1 → addr=9 with en high 2 cycles, then done. start held through the done cycle with first=2, last=3 → new scan begins with addr=2 on the next edge.
